// File: rtl/mem_exec_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the memory functional unit (mem_exec_pipe).
//   FU_MEM          functional-unit code that selects this unit
//   size_e          decoded access size (word / half / byte)
//   slot_t          one pipeline slot as seen by Writeback
//   decode_size     Issue aluop -> size_e (unknown codes behave as word)
//   is_misaligned   alignment rule for a size and byte lane
//   lane_be         byte enables for a store of a given size/lane
//   lane_replicate  store data replicated across the lanes
//   lane_extract    pick byte/half out of a RAM word and extend it
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] FU_MEM = 2'd2;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_e;

    typedef struct packed {
        logic        valid;
        logic [4:0]  regdest;
        logic        writereg;
        logic        misalign;
        logic [31:0] wbvalue;
    } slot_t;

    function automatic size_e decode_size(input logic [2:0] aluop);
        size_e sz;
        case (aluop)
            3'd1:    sz = SZ_HALF;
            3'd2:    sz = SZ_BYTE;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lane);
        logic mis;
        case (sz)
            SZ_HALF: mis = lane[0];
            SZ_BYTE: mis = 1'b0;
            default: mis = (lane != 2'd0);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_be(input size_e sz, input logic [1:0] lane);
        logic [3:0] be;
        case (sz)
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: be = 4'b0001 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // The byte enables pick the lane, so the data only has to be present in
    // every lane it could land in.
    function automatic logic [31:0] lane_replicate(input size_e sz, input logic [31:0] data);
        logic [31:0] rep;
        case (sz)
            SZ_HALF: rep = {2{data[15:0]}};
            SZ_BYTE: rep = {4{data[7:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input size_e       sz,
                                                 input logic [1:0]  lane,
                                                 input logic        unsig);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_HALF: res = unsig ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_BYTE: res = unsig ? {24'h000000, b} : {{24{b[7]}}, b};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_exec_pipe_if.sv
// -----------------------------------------------------------------------------
// mem_exec_pipe_if
// Issue -> memory unit request bundle and memory unit -> Writeback result
// bundle.
//   slave  : the memory unit (consumes is_m0_*, produces m_wb_*)
//   master : the Issue/Writeback side (produces is_m0_*, consumes m_wb_*)
// -----------------------------------------------------------------------------
interface mem_exec_pipe_if;

    logic [1:0]  is_m0_functionalunit;
    logic [2:0]  is_m0_aluop;
    logic        is_m0_unsig;
    logic [31:0] is_m0_rega;
    logic [31:0] is_m0_imedext;
    logic [31:0] is_m0_regb;
    logic        is_m0_readmem;
    logic        is_m0_writemem;
    logic        is_m0_selwsource;
    logic [4:0]  is_m0_regdest;
    logic        is_m0_writereg;

    logic        m_wb_valid;
    logic [4:0]  m_wb_regdest;
    logic        m_wb_writereg;
    logic [31:0] m_wb_wbvalue;
    logic        m_wb_misalign;

    modport slave (
        input  is_m0_functionalunit, is_m0_aluop, is_m0_unsig, is_m0_rega,
               is_m0_imedext, is_m0_regb, is_m0_readmem, is_m0_writemem,
               is_m0_selwsource, is_m0_regdest, is_m0_writereg,
        output m_wb_valid, m_wb_regdest, m_wb_writereg, m_wb_wbvalue,
               m_wb_misalign
    );

    modport master (
        output is_m0_functionalunit, is_m0_aluop, is_m0_unsig, is_m0_rega,
               is_m0_imedext, is_m0_regb, is_m0_readmem, is_m0_writemem,
               is_m0_selwsource, is_m0_regdest, is_m0_writereg,
        input  m_wb_valid, m_wb_regdest, m_wb_writereg, m_wb_wbvalue,
               m_wb_misalign
    );

endinterface

// File: rtl/mem_exec_pipe_ram_be.sv
// -----------------------------------------------------------------------------
// mem_ram_be
// Synchronous single-port 32-bit RAM with per-byte write enables and a
// registered read, 2**ADDR_W words. Built as four byte-wide banks so each
// bank is a plain inferred block RAM.
//   i_clk    clock
//   i_en     global enable; when low nothing is read or written (pipeline hold)
//   i_rd     read request; the read register updates only when set
//   i_we     write request
//   i_be     byte enables, bit n writes bits [8n+7:8n]
//   i_addr   word index
//   i_wdata  write data
//   o_rdata  registered read data (read-before-write on the same address)
// -----------------------------------------------------------------------------
module mem_ram_be #(
    parameter int ADDR_W = 7
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_rd,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [7:0] r_mem [0:DEPTH-1];
            logic [7:0] r_rd;

            always_ff @(posedge i_clk) begin
                if (i_en && i_we && i_be[gi]) begin
                    r_mem[i_addr] <= i_wdata[gi*8 +: 8];
                end
                if (i_en && i_rd) begin
                    r_rd <= r_mem[i_addr];
                end
            end

            assign o_rdata[gi*8 +: 8] = r_rd;
        end
    endgenerate

endmodule

// File: rtl/mem_exec_pipe.sv
// -----------------------------------------------------------------------------
// mem_exec_pipe
// Memory functional unit of the Execute stage. One op per cycle from Issue;
// byte address = rega + imedext; word/half/byte load or store against an
// internal byte-enabled RAM; result to Writeback PIPE_DEPTH cycles later.
//   clock  rising-edge clock
//   reset  synchronous active-high; clears every stage, RAM content is kept
//   hold   freezes all stage registers and the RAM (no write, no read update)
//   pipe   request/result bundle (mem_exec_pipe_if.slave)
// Parameters: ADDR_W word-index bits (RAM = 2**ADDR_W words),
//             PIPE_DEPTH issue-to-writeback latency in cycles, 2..8.
// Stages: M0 holds decoded op, M1 holds RAM read result, M2.. are delays.
// -----------------------------------------------------------------------------
module mem_exec_pipe
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int PIPE_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           hold,
    mem_exec_pipe_if.slave pipe
);

    // ---------------- issue decode ----------------
    logic [31:0] w_addr;
    size_e       w_size;
    logic        w_accept;
    logic        w_misalign;

    assign w_addr     = pipe.is_m0_rega + pipe.is_m0_imedext;
    assign w_size     = decode_size(pipe.is_m0_aluop);
    assign w_accept   = (pipe.is_m0_functionalunit == FU_MEM);
    assign w_misalign = is_misaligned(w_size, w_addr[1:0]);

    // ---------------- stage M0 ----------------
    logic        r_m0_valid;
    logic [4:0]  r_m0_regdest;
    logic        r_m0_writereg;
    logic        r_m0_misalign;
    logic [31:0] r_m0_addr;
    size_e       r_m0_size;
    logic        r_m0_unsig;
    logic        r_m0_read;
    logic        r_m0_write;
    logic        r_m0_selw;
    logic [31:0] r_m0_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_m0_valid    <= 1'b0;
            r_m0_regdest  <= '0;
            r_m0_writereg <= 1'b0;
            r_m0_misalign <= 1'b0;
            r_m0_addr     <= '0;
            r_m0_size     <= SZ_WORD;
            r_m0_unsig    <= 1'b0;
            r_m0_read     <= 1'b0;
            r_m0_write    <= 1'b0;
            r_m0_selw     <= 1'b0;
            r_m0_wdata    <= '0;
        end else if (!hold) begin
            if (w_accept) begin
                r_m0_valid    <= 1'b1;
                r_m0_regdest  <= pipe.is_m0_regdest;
                r_m0_writereg <= pipe.is_m0_writereg & ~w_misalign;
                r_m0_misalign <= w_misalign;
                r_m0_addr     <= w_addr;
                r_m0_size     <= w_size;
                r_m0_unsig    <= pipe.is_m0_unsig;
                r_m0_read     <= pipe.is_m0_readmem;
                r_m0_write    <= pipe.is_m0_writemem;
                r_m0_selw     <= pipe.is_m0_selwsource;
                r_m0_wdata    <= lane_replicate(w_size, pipe.is_m0_regb);
            end else begin
                // Non-memory op: the slot becomes an all-zero bubble.
                r_m0_valid    <= 1'b0;
                r_m0_regdest  <= '0;
                r_m0_writereg <= 1'b0;
                r_m0_misalign <= 1'b0;
                r_m0_addr     <= '0;
                r_m0_size     <= SZ_WORD;
                r_m0_unsig    <= 1'b0;
                r_m0_read     <= 1'b0;
                r_m0_write    <= 1'b0;
                r_m0_selw     <= 1'b0;
                r_m0_wdata    <= '0;
            end
        end
    end

    // ---------------- RAM (commits/reads on the M1 edge) ----------------
    logic        w_ram_we;
    logic [31:0] w_rdata;

    // Gating with reset drops a store sitting in M0 when reset hits.
    assign w_ram_we = r_m0_valid & r_m0_write & ~r_m0_misalign & ~reset;

    mem_ram_be #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .i_clk  (clock),
        .i_en   (~hold),
        .i_rd   (r_m0_valid & r_m0_read),
        .i_we   (w_ram_we),
        .i_be   (lane_be(r_m0_size, r_m0_addr[1:0])),
        .i_addr (r_m0_addr[ADDR_W+1:2]),
        .i_wdata(r_m0_wdata),
        .o_rdata(w_rdata)
    );

    // ---------------- stage M1 ----------------
    logic        r_m1_valid;
    logic [4:0]  r_m1_regdest;
    logic        r_m1_writereg;
    logic        r_m1_misalign;
    logic [31:0] r_m1_addr;
    size_e       r_m1_size;
    logic        r_m1_unsig;
    logic        r_m1_selw;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_m1_valid    <= 1'b0;
            r_m1_regdest  <= '0;
            r_m1_writereg <= 1'b0;
            r_m1_misalign <= 1'b0;
            r_m1_addr     <= '0;
            r_m1_size     <= SZ_WORD;
            r_m1_unsig    <= 1'b0;
            r_m1_selw     <= 1'b0;
        end else if (!hold) begin
            r_m1_valid    <= r_m0_valid;
            r_m1_regdest  <= r_m0_regdest;
            r_m1_writereg <= r_m0_writereg;
            r_m1_misalign <= r_m0_misalign;
            r_m1_addr     <= r_m0_addr;
            r_m1_size     <= r_m0_size;
            r_m1_unsig    <= r_m0_unsig;
            r_m1_selw     <= r_m0_selw;
        end
    end

    // The RAM output register is the M1 data register; extension sits after it.
    slot_t w_m1_slot;

    always_comb begin
        w_m1_slot          = '0;
        w_m1_slot.valid    = r_m1_valid;
        w_m1_slot.regdest  = r_m1_regdest;
        w_m1_slot.writereg = r_m1_writereg;
        w_m1_slot.misalign = r_m1_misalign;
        if (r_m1_valid) begin
            if (r_m1_misalign || !r_m1_selw) begin
                w_m1_slot.wbvalue = r_m1_addr;
            end else begin
                w_m1_slot.wbvalue = lane_extract(w_rdata, r_m1_size,
                                                 r_m1_addr[1:0], r_m1_unsig);
            end
        end
    end

    // ---------------- delay stages M2..M(PIPE_DEPTH-1) ----------------
    slot_t w_slot [1:PIPE_DEPTH-1];

    assign w_slot[1] = w_m1_slot;

    genvar gi;
    generate
        for (gi = 2; gi < PIPE_DEPTH; gi++) begin : g_dly
            slot_t r_dly;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_dly <= '0;
                end else if (!hold) begin
                    r_dly <= w_slot[gi-1];
                end
            end

            assign w_slot[gi] = r_dly;
        end
    endgenerate

    // ---------------- writeback outputs ----------------
    assign pipe.m_wb_valid    = w_slot[PIPE_DEPTH-1].valid;
    assign pipe.m_wb_regdest  = w_slot[PIPE_DEPTH-1].regdest;
    assign pipe.m_wb_writereg = w_slot[PIPE_DEPTH-1].writereg;
    assign pipe.m_wb_misalign = w_slot[PIPE_DEPTH-1].misalign;
    assign pipe.m_wb_wbvalue  = w_slot[PIPE_DEPTH-1].wbvalue;

endmodule

// File: tb/tb_mem_exec_pipe.sv
// -----------------------------------------------------------------------------
// tb_mem_exec_pipe
// Directed + random stimulus for mem_exec_pipe. The reference is a byte-array
// memory plus an in-order list of ops in flight: each op takes effect on the
// memory one effective cycle after issue (program order), and emerges
// PIPE_DEPTH effective cycles after issue. Held cycles leave everything as is,
// reset discards every op in flight.
// -----------------------------------------------------------------------------
module tb_mem_exec_pipe;

    localparam int AW     = 7;
    localparam int P      = 4;
    localparam int NBYTES = 4 * (2 ** AW);

    logic clock = 1'b0;
    logic reset;
    logic hold;

    mem_exec_pipe_if bus ();

    mem_exec_pipe #(
        .ADDR_W    (AW),
        .PIPE_DEPTH(P)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hold (hold),
        .pipe (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [4:0]  regdest;
        logic        writereg;
        logic        misalign;
        logic [31:0] wbvalue;
        logic        ld;
        logic        st;
        int          sz;      // 0 word, 1 half, 2 byte
        logic        unsig;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t        q[$];
    logic [7:0] mm [0:NBYTES-1];
    int         n_cmp  = 0;
    int         n_fail = 0;

    function automatic op_t bubble();
        op_t o;
        o.valid = 0; o.regdest = 0; o.writereg = 0; o.misalign = 0;
        o.wbvalue = 0; o.ld = 0; o.st = 0; o.sz = 0; o.unsig = 0;
        o.addr = 0; o.data = 0;
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Memory effect of one op, applied in program order.
    task automatic commit(inout op_t o);
        int a, base;
        logic [15:0] h;
        logic [7:0]  b;
        if (!o.valid || o.misalign) return;
        a    = int'(o.addr[AW+1:0]);
        base = a - (a % 4);
        if (o.ld) begin
            if (o.sz == 1) begin
                h = {mm[a+1], mm[a]};
                o.wbvalue = o.unsig ? {16'h0, h} : {{16{h[15]}}, h};
            end else if (o.sz == 2) begin
                b = mm[a];
                o.wbvalue = o.unsig ? {24'h0, b} : {{24{b[7]}}, b};
            end else begin
                o.wbvalue = {mm[base+3], mm[base+2], mm[base+1], mm[base]};
            end
        end
        if (o.st) begin
            if (o.sz == 1) begin
                mm[a]   = o.data[7:0];
                mm[a+1] = o.data[15:8];
            end else if (o.sz == 2) begin
                mm[a] = o.data[7:0];
            end else begin
                for (int i = 0; i < 4; i++) mm[base+i] = o.data[8*i +: 8];
            end
        end
    endtask

    // One clock cycle: drive, clock, update model, compare.
    task automatic cyc(input logic h, input logic r, input logic [1:0] fu,
                       input logic [2:0] aop, input logic uns,
                       input logic [31:0] ra, input logic [31:0] im, input logic [31:0] rb,
                       input logic rd, input logic wr, input logic sw,
                       input logic [4:0] dst, input logic wreg);
        op_t o, t, e;
        hold = h; reset = r;
        bus.is_m0_functionalunit = fu;
        bus.is_m0_aluop          = aop;
        bus.is_m0_unsig          = uns;
        bus.is_m0_rega           = ra;
        bus.is_m0_imedext        = im;
        bus.is_m0_regb           = rb;
        bus.is_m0_readmem        = rd;
        bus.is_m0_writemem       = wr;
        bus.is_m0_selwsource     = sw;
        bus.is_m0_regdest        = dst;
        bus.is_m0_writereg       = wreg;
        @(posedge clock);
        if (r) begin
            q.delete();
            repeat (P) q.push_back(bubble());
        end else if (!h) begin
            o = bubble();
            if (fu == 2'd2) begin
                o.valid    = 1;
                o.sz       = (aop == 3'd1) ? 1 : (aop == 3'd2) ? 2 : 0;
                o.addr     = ra + im;
                o.misalign = (o.sz == 1 && o.addr[0]) || (o.sz == 0 && o.addr[1:0] != 2'b00);
                o.regdest  = dst;
                o.writereg = wreg && !o.misalign;
                o.wbvalue  = o.addr;
                o.ld       = rd && sw;
                o.st       = wr;
                o.unsig    = uns;
                o.data     = rb;
            end
            q.push_back(o);
            t = q[q.size()-2];
            commit(t);
            q[q.size()-2] = t;
            while (q.size() > P) void'(q.pop_front());
        end
        #1;
        e = q[0];
        check("valid",    32'(bus.m_wb_valid),    32'(e.valid));
        check("misalign", 32'(bus.m_wb_misalign), 32'(e.misalign));
        check("writereg", 32'(bus.m_wb_writereg), 32'(e.writereg));
        check("regdest",  32'(bus.m_wb_regdest),  32'(e.regdest));
        check("wbvalue",  bus.m_wb_wbvalue,       e.wbvalue);
    endtask

    task automatic idle(input logic h, input logic r);
        cyc(h, r, 2'd0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic st(input logic [2:0] aop, input logic [31:0] ra, input logic [31:0] im,
                      input logic [31:0] data);
        cyc(1'b0, 1'b0, 2'd2, aop, 1'b0, ra, im, data, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic ld(input logic [2:0] aop, input logic uns, input logic [31:0] ra,
                      input logic [31:0] im, input logic [4:0] dst);
        cyc(1'b0, 1'b0, 2'd2, aop, uns, ra, im, $urandom, 1'b1, 1'b0, 1'b1, dst, 1'b1);
    endtask

    initial begin
        logic        h, r, uns, rd, wr, sw, wreg;
        logic [1:0]  fu;
        logic [2:0]  aop;
        logic [31:0] ra, im, rb;
        logic [4:0]  dst;
        int          kind;

        repeat (P) q.push_back(bubble());

        // Reset state, including reset winning over hold.
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);

        // Give every RAM word a known value.
        for (int i = 0; i < 2 ** AW; i++) st(3'd0, 32'(i * 4), 32'h0, $urandom);
        repeat (P) idle(1'b0, 1'b0);

        // Word store then load.
        st(3'd0, 32'h10, 32'h0, 32'hDEADBEEF);
        ld(3'd0, 1'b0, 32'h10, 32'h0, 5'd3);
        // Byte store, signed / unsigned byte loads, word readback.
        st(3'd2, 32'h13, 32'h0, 32'h00000080);
        ld(3'd2, 1'b0, 32'h13, 32'h0, 5'd4);
        ld(3'd2, 1'b1, 32'h13, 32'h0, 5'd5);
        ld(3'd0, 1'b0, 32'h10, 32'h0, 5'd6);
        // Misaligned half load, misaligned word store, readback.
        ld(3'd1, 1'b0, 32'h11, 32'h0, 5'd7);
        st(3'd0, 32'h12, 32'h0, 32'h11223344);
        ld(3'd0, 1'b0, 32'h10, 32'h0, 5'd8);
        // Store/load stream with a 3-cycle hold in the middle.
        st(3'd0, 32'h20, 32'h0, 32'hCAFEF00D);
        ld(3'd0, 1'b0, 32'h20, 32'h0, 5'd9);
        st(3'd1, 32'h1E, 32'h4, 32'h0000BEEF);
        repeat (3) cyc(1'b1, 1'b0, 2'd2, 3'd0, 1'b0, 32'h20, 32'h0, 32'h0BADBAD0,
                       1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
        ld(3'd1, 1'b1, 32'h22, 32'h0, 5'd10);
        ld(3'd0, 1'b0, 32'h20, 32'h0, 5'd11);
        repeat (P) idle(1'b0, 1'b0);
        // Address wrap: 0xFFFFFFFC + 8 lands on word index 1.
        st(3'd0, 32'hFFFFFFFC, 32'h8, 32'h12345678);
        ld(3'd0, 1'b0, 32'h4, 32'h0, 5'd12);
        ld(3'd0, 1'b0, 32'h00000204, 32'h0, 5'd13);
        repeat (P) idle(1'b0, 1'b0);
        // Reset with a store in M0 and a load in M2.
        ld(3'd0, 1'b0, 32'h10, 32'h0, 5'd14);
        idle(1'b0, 1'b0);
        st(3'd0, 32'h10, 32'h0, 32'h55555555);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        ld(3'd0, 1'b0, 32'h10, 32'h0, 5'd15);
        repeat (P) idle(1'b0, 1'b0);

        // Random mix.
        for (int n = 0; n < 400; n++) begin
            h    = ($urandom_range(0, 7) == 0);
            r    = ($urandom_range(0, 63) == 0);
            kind = $urandom_range(0, 9);
            fu   = (kind == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            aop  = 3'($urandom_range(0, 7));
            uns  = 1'($urandom);
            ra   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 127));
            im   = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 1) == 1) begin
                ra = {ra[31:2], 2'b00};
                im = {im[31:2], 2'b00};
            end
            rb   = $urandom;
            dst  = 5'($urandom);
            wreg = 1'($urandom);
            if (kind < 5) begin
                rd = 1; wr = 0; sw = 1;
            end else if (kind < 8) begin
                rd = 0; wr = 1; sw = 0;
            end else begin
                rd = 0; wr = 0; sw = 0;
            end
            cyc(h, r, fu, aop, uns, ra, im, rb, rd, wr, sw, dst, wreg);
        end
        repeat (P + 1) idle(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
